// File: rtl/sim_ctrl_pkg.sv
// rtl/sim_ctrl_pkg.sv - shared types and constants for the simulation run controller
// Provides the controller state enum, the termination status codes and the
// width helper used to size the halt-source index.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_HALT    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_HANG    = 2'd3;

    // A single channel still gets a 1-bit index so the port never vanishes.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sim_run_ctrl_if.sv
// rtl/sim_run_ctrl_if.sv - harness-side bundle between the bench and the run controller
// Signals:
//   halt_req  [N_SRC]  per-channel halt request level (bench -> controller)
//   commit             one pulse per retired instruction (bench -> controller)
//   cpu_rst            active-high core reset (controller -> bench)
//   done               sticky run-terminated flag
//   status    [2]      termination cause
//   halt_src  [SRC_W]  index of the halting channel
//   cycle_cnt [CNT_W]  RUN cycles elapsed
// Modports: master = harness/bench side, slave = controller side.
interface sim_run_ctrl_if #(
    parameter int N_SRC = 2,
    parameter int CNT_W = 32
);
    import sim_ctrl_pkg::*;

    localparam int SRC_W = src_width(N_SRC);

    logic [N_SRC-1:0] halt_req;
    logic             commit;
    logic             cpu_rst;
    logic             done;
    logic [1:0]       status;
    logic [SRC_W-1:0] halt_src;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output halt_req, commit,
        input  cpu_rst, done, status, halt_src, cycle_cnt
    );

    modport slave (
        input  halt_req, commit,
        output cpu_rst, done, status, halt_src, cycle_cnt
    );

endinterface

// File: rtl/prio_enc.sv
// rtl/prio_enc.sv - lowest-index-wins priority encoder for halt channels
// Ports:
//   i_req [N]  request vector
//   o_any      at least one request set
//   o_idx [W]  index of the lowest set request (0 when none)
module prio_enc #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] i_req,
    output logic         o_any,
    output logic [W-1:0] o_idx
);

    assign o_any = |i_req;

    // Scan from the top down so the lowest set bit is the last to write.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// rtl/sim_run_ctrl.sv - core reset stretch, halt detect, timeout and hang watchdog
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   ctl    sim_run_ctrl_if.slave: halt_req/commit in; cpu_rst, done,
//          status, halt_src, cycle_cnt out (all registered)
// Runs HOLD -> RUN -> DONE; DONE is left only through rst_n.
module sim_run_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int RST_HOLD    = 25,
    parameter int N_SRC       = 2,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 150000000,
    parameter int STALL_LIMIT = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    sim_run_ctrl_if.slave ctl
);

    localparam int SRC_W = src_width(N_SRC);

    // Comparisons use pre-increment values, hence the "-1" terminal counts.
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'((STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1);
    localparam bit               WDOG_EN    = (STALL_LIMIT != 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic             r_cpu_rst;
    logic             r_done;
    logic [1:0]       r_status;
    logic [SRC_W-1:0] r_halt_src;

    logic             w_any;
    logic [SRC_W-1:0] w_idx;
    logic             w_timeout;
    logic             w_hang;

    prio_enc #(
        .N (N_SRC),
        .W (SRC_W)
    ) u_prio_enc (
        .i_req (ctl.halt_req),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    assign w_timeout = (r_cycle_cnt == TO_LAST);
    // A commit on the would-be terminal cycle rescues the run.
    assign w_hang    = WDOG_EN && (r_stall_cnt == STALL_LAST) && !ctl.commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HOLD;
            r_hold_cnt  <= '0;
            r_stall_cnt <= '0;
            r_cycle_cnt <= '0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_status    <= ST_NONE;
            r_halt_src  <= '0;
        end else begin
            case (r_state)
                HOLD: begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state   <= RUN;
                        r_cpu_rst <= 1'b0;
                    end
                end
                RUN: begin
                    r_cycle_cnt <= r_cycle_cnt + 1'b1;
                    r_stall_cnt <= ctl.commit ? '0 : r_stall_cnt + 1'b1;
                    if (w_any || w_timeout || w_hang) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_cpu_rst <= 1'b1;
                        if (w_any) begin
                            r_status   <= ST_HALT;
                            r_halt_src <= w_idx;
                        end else if (w_timeout) begin
                            r_status <= ST_TIMEOUT;
                        end else begin
                            r_status <= ST_HANG;
                        end
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= HOLD;
                end
            endcase
        end
    end

    assign ctl.cpu_rst   = r_cpu_rst;
    assign ctl.done      = r_done;
    assign ctl.status    = r_status;
    assign ctl.halt_src  = r_halt_src;
    assign ctl.cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb/tb_sim_run_ctrl.sv - self-checking bench for sim_run_ctrl against a run-level model
module tb_sim_run_ctrl;

    localparam int P_HOLD  = 5;
    localparam int P_NSRC  = 4;
    localparam int P_CNTW  = 32;
    localparam int P_TO    = 64;
    localparam int P_STALL = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edges seen since release, RUN cycles, idle run length.
    int m_edges;
    int m_cyc;
    int m_idle;
    bit m_done;
    int m_status;
    int m_src;

    always #5 clk = ~clk;

    sim_run_ctrl_if #(.N_SRC(P_NSRC), .CNT_W(P_CNTW)) ctl ();

    sim_run_ctrl #(
        .RST_HOLD    (P_HOLD),
        .N_SRC       (P_NSRC),
        .CNT_W       (P_CNTW),
        .TIMEOUT     (P_TO),
        .STALL_LIMIT (P_STALL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ctl)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_edges  = 0;
        m_cyc    = 0;
        m_idle   = 0;
        m_done   = 1'b0;
        m_status = 0;
        m_src    = 0;
    endtask

    // One rising edge with rst_n high, inputs as sampled at that edge.
    task automatic model_edge(input logic [P_NSRC-1:0] req, input bit com);
        if (m_done) return;
        if (m_edges < P_HOLD) begin
            m_edges++;
            return;
        end
        m_cyc++;
        m_idle = com ? 0 : m_idle + 1;
        if (req != 0) begin
            m_done   = 1'b1;
            m_status = 1;
            for (int i = 0; i < P_NSRC; i++) begin
                if (req[i]) begin
                    m_src = i;
                    break;
                end
            end
        end else if (m_cyc == P_TO) begin
            m_done   = 1'b1;
            m_status = 2;
        end else if (P_STALL != 0 && !com && m_idle == P_STALL) begin
            m_done   = 1'b1;
            m_status = 3;
        end
    endtask

    task automatic check_all();
        chk("cpu_rst",   32'(ctl.cpu_rst),   32'((m_edges < P_HOLD) || m_done));
        chk("done",      32'(ctl.done),      32'(m_done));
        chk("status",    32'(ctl.status),    32'(m_status));
        chk("halt_src",  32'(ctl.halt_src),  32'(m_src));
        chk("cycle_cnt", 32'(ctl.cycle_cnt), 32'(m_cyc));
    endtask

    // Called just after a rising edge; checks the async clear before the next edge.
    task automatic apply_reset();
        ctl.halt_req = 4'($urandom);
        ctl.commit   = 1'($urandom);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [P_NSRC-1:0] req, input bit com);
        ctl.halt_req = req;
        ctl.commit   = com;
        @(posedge clk);
        model_edge(req, com);
        #1;
        check_all();
    endtask

    // HOLD must ignore any input activity.
    task automatic hold_phase();
        for (int i = 0; i < P_HOLD; i++) begin
            step(4'($urandom), 1'($urandom));
        end
        chk("hold_released", 32'(ctl.cpu_rst), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        ctl.halt_req = '0;
        ctl.commit   = 1'b0;
        #1;
        apply_reset();
        chk("reset_status", 32'(ctl.status), 32'd0);
        chk("reset_done",   32'(ctl.done),   32'd0);

        // Reset stretch: cpu_rst high for exactly P_HOLD edges.
        for (int i = 0; i < P_HOLD; i++) begin
            chk("stretch_pre", 32'(ctl.cpu_rst), 32'd1);
            step(4'($urandom), 1'($urandom));
        end
        chk("stretch_post", 32'(ctl.cpu_rst), 32'd0);

        // Halt priority at RUN cycle 10.
        for (int i = 0; i < 10; i++) step('0, 1'b1);
        step(4'b1010, 1'b1);
        chk("halt_status",  32'(ctl.status),    32'd1);
        chk("halt_src",     32'(ctl.halt_src),  32'd1);
        chk("halt_cnt",     32'(ctl.cycle_cnt), 32'd11);
        chk("halt_cpu_rst", 32'(ctl.cpu_rst),   32'd1);
        for (int i = 0; i < 20; i++) step(4'($urandom), 1'($urandom));

        // Reset while in DONE, then timeout.
        apply_reset();
        hold_phase();
        c = 0;
        while (!ctl.done && c < 100) begin
            step('0, (c % 3) == 0);
            c++;
        end
        chk("to_latency", 32'(c),             32'(P_TO));
        chk("to_status",  32'(ctl.status),    32'd2);
        chk("to_cnt",     32'(ctl.cycle_cnt), 32'(P_TO));
        for (int i = 0; i < 100; i++) step(4'($urandom), 1'($urandom));
        chk("to_sticky_status", 32'(ctl.status),    32'd2);
        chk("to_sticky_cnt",    32'(ctl.cycle_cnt), 32'(P_TO));

        // Reset mid-RUN.
        apply_reset();
        hold_phase();
        for (int i = 0; i < 7; i++) step('0, 1'b1);
        apply_reset();
        chk("midrun_cnt", 32'(ctl.cycle_cnt), 32'd0);
        hold_phase();

        // Hang: commits every 3 cycles for 30 cycles, then silence.
        for (int i = 0; i < 30; i++) step('0, (i % 3) == 0);
        n = 0;
        while (!ctl.done && n < 40) begin
            step('0, 1'b0);
            n++;
        end
        chk("hang_gap",    32'(n + 2),         32'(P_STALL));
        chk("hang_status", 32'(ctl.status),    32'd3);
        chk("hang_cnt",    32'(ctl.cycle_cnt), 32'(30 + n));

        // Halt on the timeout cycle wins.
        apply_reset();
        hold_phase();
        for (int i = 0; i < P_TO - 1; i++) step('0, 1'b1);
        step(4'b0100, 1'b1);
        chk("sim_status", 32'(ctl.status),    32'd1);
        chk("sim_src",    32'(ctl.halt_src),  32'd2);
        chk("sim_cnt",    32'(ctl.cycle_cnt), 32'(P_TO));

        // Timeout and hang on the same cycle: timeout wins.
        apply_reset();
        hold_phase();
        for (int i = 0; i < P_TO - P_STALL; i++) step('0, 1'b1);
        for (int i = 0; i < P_STALL; i++) step('0, 1'b0);
        chk("tohang_status", 32'(ctl.status), 32'd2);

        // Randomized runs against the model.
        for (int r = 0; r < 8; r++) begin
            apply_reset();
            hold_phase();
            for (int i = 0; i < 120 && !ctl.done; i++) begin
                logic [P_NSRC-1:0] rq;
                rq = ($urandom_range(0, 49) == 0) ? P_NSRC'($urandom) : '0;
                step(rq, $urandom_range(0, r + 1) == 0);
            end
            for (int i = 0; i < 10; i++) step(4'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
